// File: rtl/tsb_pkg.sv
// ---------------------------------------------------------------------------
// tsb_pkg
// Shared definitions for the tri-state bus controller:
//   - state encodings IDLE / DRIVE / TURN and the FSM state type
//   - clog2 helper used to size owner index and counters
// ---------------------------------------------------------------------------
package tsb_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] DRIVE_ENC = 2'd1;
    localparam logic [1:0] TURN_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        DRIVE = DRIVE_ENC,
        TURN  = TURN_ENC
    } tsb_state_e;

    // Ceiling log2; callers only pass values >= 2, so the result is >= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after rr_ptr, wrapping from NUM_CH-1 back to 0.
// Ports:
//   req        in   NUM_CH            request vector
//   rr_ptr     in   clog2(NUM_CH)     highest-priority index
//   gnt_onehot out  NUM_CH            one-hot winner (0 when no request)
//   gnt_idx    out  clog2(NUM_CH)     index of winner (0 when no request)
//   any        out  1                 at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import tsb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]               req,
    input  logic [tsb_pkg::clog2(NUM_CH)-1:0] rr_ptr,
    output logic [NUM_CH-1:0]               gnt_onehot,
    output logic [tsb_pkg::clog2(NUM_CH)-1:0] gnt_idx,
    output logic                            any
);

    localparam int IDW = tsb_pkg::clog2(NUM_CH);

    // Walk offsets from the farthest to the nearest so the candidate closest
    // to rr_ptr is the one that survives.
    always_comb begin
        int idx;
        idx        = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = |req;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (req[idx]) begin
                gnt_onehot      = '0;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/tri_state_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tri_state_bus_ctrl
// Multi-channel tri-state bus driver. NUM_CH producers share one DATA_WIDTH
// bus through round-robin arbitration; each owner may drive for at most
// MAX_BEATS consecutive cycles, and the bus is released for TURN_CYCLES
// cycles between owners so two drivers never overlap.
// Ports:
//   clk        in   1                  rising-edge clock
//   rst        in   1                  synchronous active-high reset
//   req        in   NUM_CH             per-channel level request
//   data_in    in   NUM_CH*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   grant      out  NUM_CH             one-hot registered owner
//   owner_id   out  clog2(NUM_CH)      current or last owner index
//   bus_valid  out  1                  bus driven by an owner this cycle
//   y_out      out  DATA_WIDTH         tri-state bus
// Build option:
//   TSB_BUS_KEEPER_EN  when defined, y_out holds the last driven value
//                      (0 after reset) instead of floating when released.
// ---------------------------------------------------------------------------
module tri_state_bus_ctrl
    import tsb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CH      = 4,
    parameter int MAX_BEATS   = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  req,
    input  logic [NUM_CH*DATA_WIDTH-1:0]       data_in,
    output logic [NUM_CH-1:0]                  grant,
    output logic [tsb_pkg::clog2(NUM_CH)-1:0]  owner_id,
    output logic                               bus_valid,
    output logic [DATA_WIDTH-1:0]              y_out
);

    localparam int IDW = tsb_pkg::clog2(NUM_CH);
    localparam int BW  = tsb_pkg::clog2(MAX_BEATS + 1);
    localparam int TW  = tsb_pkg::clog2(TURN_CYCLES + 1);

    localparam logic [BW-1:0]  BEAT_LIMIT = BW'(MAX_BEATS);
    localparam logic [TW-1:0]  TURN_LIMIT = TW'(TURN_CYCLES);
    localparam logic [IDW-1:0] LAST_CH    = IDW'(NUM_CH - 1);

    // Registered state
    tsb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [IDW-1:0]    owner_id_q, owner_id_d;
    logic              bus_valid_q, bus_valid_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]     turn_cnt_q, turn_cnt_d;

    // Arbiter outputs
    logic [NUM_CH-1:0] arb_onehot;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;

    // Per-channel view of the packed data bus
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [DATA_WIDTH-1:0] drive_val;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign ch_data[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_id_d  = owner_id_q;
        bus_valid_d = bus_valid_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        turn_cnt_d  = turn_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d     = DRIVE;
                    grant_d     = arb_onehot;
                    owner_id_d  = arb_idx;
                    bus_valid_d = 1'b1;
                    beat_cnt_d  = BW'(1);
                end
            end

            DRIVE: begin
                // Owner dropping its request and hitting the burst cap are
                // merged into one exit so the bus only turns around once.
                if (!req[owner_id_q] || (beat_cnt_q == BEAT_LIMIT)) begin
                    state_d     = TURN;
                    grant_d     = '0;
                    bus_valid_d = 1'b0;
                    rr_ptr_d    = (owner_id_q == LAST_CH) ? '0 : owner_id_q + 1'b1;
                    turn_cnt_d  = TW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end

            TURN: begin
                if (turn_cnt_q == TURN_LIMIT) begin
                    // rr_ptr already points past the released owner, so it
                    // only wins again when nobody else is asking.
                    if (arb_any) begin
                        state_d     = DRIVE;
                        grant_d     = arb_onehot;
                        owner_id_d  = arb_idx;
                        bus_valid_d = 1'b1;
                        beat_cnt_d  = BW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_id_q  <= '0;
            bus_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            turn_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_id_q  <= owner_id_d;
            bus_valid_q <= bus_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grant     = grant_q;
    assign owner_id  = owner_id_q;
    assign bus_valid = bus_valid_q;

    // Data path is combinational from the registered owner so data changes
    // during a burst appear on the bus in the same cycle.
    assign drive_val = ch_data[owner_id_q];

`ifdef TSB_BUS_KEEPER_EN
    logic [DATA_WIDTH-1:0] keep_q, keep_d;

    always_comb begin
        keep_d = keep_q;
        if (bus_valid_q) begin
            keep_d = drive_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keep_q <= '0;
        end else begin
            keep_q <= keep_d;
        end
    end

    assign y_out = bus_valid_q ? drive_val : keep_q;
`else
    assign y_out = bus_valid_q ? drive_val : {DATA_WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_tri_state_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tri_state_bus_ctrl
// Directed bench for tri_state_bus_ctrl with default parameters
// (DATA_WIDTH=8, NUM_CH=4, MAX_BEATS=8, TURN_CYCLES=1). Works with or
// without TSB_BUS_KEEPER_EN; the released-bus value follows the build.
// ---------------------------------------------------------------------------
module tb_tri_state_bus_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [1:0]  owner_id;
    logic        bus_valid;
    logic [7:0]  y_out;

    logic [7:0]  ch_data [4];
    logic [7:0]  last_drv;
    int          vectors_applied;
    int          miscompares;
    int          cyc;

    assign data_in = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    tri_state_bus_ctrl #(
        .DATA_WIDTH  (8),
        .NUM_CH      (4),
        .MAX_BEATS   (8),
        .TURN_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .owner_id  (owner_id),
        .bus_valid (bus_valid),
        .y_out     (y_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Value the bus shows while released: floating, or the held value.
    function automatic logic [7:0] idle_val();
`ifdef TSB_BUS_KEEPER_EN
        return last_drv;
`else
        return 8'bzzzz_zzzz;
`endif
    endfunction

    task automatic step(input string what);
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d %s: req=%b grant=%b owner=%0d valid=%b y=%h",
                 cyc, what, req, grant, owner_id, bus_valid, y_out);
        chk("onehot", ($countones(grant) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_drive(input string tag, input int ch);
        chk({tag, "_grant"}, 32'(grant), 32'(1) << ch);
        chk({tag, "_owner"}, 32'(owner_id), 32'(ch));
        chk({tag, "_valid"}, 32'(bus_valid), 32'd1);
        chk({tag, "_y"}, 32'(y_out), 32'(ch_data[ch]));
        last_drv = ch_data[ch];
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
        chk({tag, "_y"}, 32'(y_out), 32'(idle_val()));
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        cyc             = 0;
        last_drv        = 8'h00;
        ch_data[0] = 8'h10;
        ch_data[1] = 8'h21;
        ch_data[2] = 8'hA5;
        ch_data[3] = 8'h43;

        // Reset held for two clocks with every channel requesting.
        rst = 1'b1;
        req = 4'hF;
        step("reset");
        check_idle("rst0");
        chk("rst0_owner", 32'(owner_id), 32'd0);
        step("reset");
        check_idle("rst1");
        rst = 1'b0;

        // Full rotation 0,1,2,3,0 with 8 beats each and a single Z gap.
        for (int r = 0; r < 5; r++) begin
            for (int b = 1; b <= 8; b++) begin
                step("rot_drive");
                check_drive("rot", r % 4);
            end
            step("rot_turn");
            check_idle("rot_turn");
        end

        // Reset in the middle of ch3 beat 4 (rr_ptr is 1, ch3 sole requester).
        req = 4'b1000;
        for (int b = 1; b <= 4; b++) begin
            step("ch3_drive");
            check_drive("ch3", 3);
        end
        rst      = 1'b1;
        last_drv = 8'h00;
        step("mid_rst");
        check_idle("mid_rst");
        chk("mid_rst_owner", 32'(owner_id), 32'd0);
        rst = 1'b0;
        req = 4'hF;
        step("post_rst");
        check_drive("post_rst", 0);
        req = 4'h0;
        step("post_rst_turn");
        check_idle("post_rst_turn");
        step("post_rst_idle");
        check_idle("post_rst_idle");
        chk("last_owner_kept", 32'(owner_id), 32'd0);

        // Single requester ch2, drops after three beats.
        req = 4'b0100;
        for (int b = 1; b <= 3; b++) begin
            step("single");
            check_drive("single", 2);
        end
        req = 4'b0000;
        step("single_turn");
        check_idle("single_turn");
        step("single_idle");
        check_idle("single_idle");
        step("single_idle2");
        check_idle("single_idle2");
        chk("single_owner", 32'(owner_id), 32'd2);

        // Burst cap: ch1 alone for 8 beats, one gap, then re-granted.
        req = 4'b0010;
        for (int b = 1; b <= 8; b++) begin
            step("burst");
            check_drive("burst", 1);
            if (b == 2) begin
                ch_data[1] = 8'h5A;
                #1;
                chk("burst_live_y", 32'(y_out), 32'h5A);
                ch_data[1] = 8'h21;
            end
        end
        step("burst_turn");
        check_idle("burst_turn");
        step("burst_regrant");
        check_drive("burst_regrant", 1);
        req = 4'b0000;
        step("burst_end_turn");
        check_idle("burst_end_turn");
        step("burst_end_idle");
        check_idle("burst_end_idle");

        // Released-bus value after ch2 drives 8'h3C.
        ch_data[2] = 8'h3C;
        req = 4'b0100;
        step("keep_drive");
        check_drive("keep_drive", 2);
        req = 4'b0000;
        step("keep_turn");
        check_idle("keep_turn");
        step("keep_idle");
        check_idle("keep_idle");

        // rr_ptr=3, only ch0 and ch2 requesting: search wraps to ch0.
        req = 4'b0101;
        step("wrap");
        check_drive("wrap", 0);
        req = 4'b0000;
        step("wrap_turn");
        check_idle("wrap_turn");
        step("wrap_idle");
        check_idle("wrap_idle");

        // rr_ptr=1 with ch0, ch2, ch3 requesting: ch2 is next in order.
        req = 4'b1101;
        step("prio");
        check_drive("prio", 2);
        req = 4'b0000;
        step("prio_turn");
        check_idle("prio_turn");
        step("prio_idle");
        check_idle("prio_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
